// File: rtl/countdown_pkg.sv
// Shared types and helpers for the countdown timer slice.
// Optional feature macro used by this slice: COUNTDOWN_AUTO_RELOAD_EN.
package countdown_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } countdown_state_t;

  localparam int unsigned CD_STATE_W = 2;

  // Prescaler count width; a zero prescale still needs one (constant) bit.
  function automatic int unsigned cd_prescale_width(input int unsigned prescale);
    return (prescale > 0) ? $clog2(prescale + 1) : 1;
  endfunction

endpackage

// File: rtl/countdown_prescaler.sv
// Tick generator: one tick every PRESCALE+1 enabled cycles, restarting on clear.
module countdown_prescaler
  import countdown_pkg::*;
#(
  parameter int unsigned PRESCALE = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int unsigned    PW   = cd_prescale_width(PRESCALE);
  localparam logic [PW-1:0]  LAST = PW'(PRESCALE);

  logic [PW-1:0] cnt_q, cnt_d;

  assign tick = enable && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// Loadable prescaled down-counter with expiry pulse and sticky under-run flag.
// Define COUNTDOWN_AUTO_RELOAD_EN to reload from the last loaded value on expiry.
module countdown_timer
  import countdown_pkg::*;
#(
  parameter int unsigned COUNTER_MSB = 7,
  parameter int unsigned PRESCALE    = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_valid,
  output logic                 load_ready,
  input  logic [COUNTER_MSB:0] load_value,
  input  logic                 start,
  input  logic                 stop,
  output logic [COUNTER_MSB:0] counter,
  output logic                 busy,
  output logic                 expired,
  output logic                 under_run
);

  localparam int unsigned CW = COUNTER_MSB + 1;
  localparam logic [COUNTER_MSB:0] ONE = CW'(1);

  countdown_state_t    state_q, state_d;
  logic [COUNTER_MSB:0] count_q, count_d;
  logic                under_run_q, under_run_d;
  logic                expired_q, expired_d;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
  logic [COUNTER_MSB:0] reload_q, reload_d;
`endif

  logic load_fire;
  logic pre_enable;
  logic tick;

  assign load_fire  = load_valid && load_ready;
  // A stop cycle clears the prescaler, which also discards a coincident tick.
  assign pre_enable = (state_q == RUN) && !stop;

  countdown_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .clear  (!pre_enable),
    .enable (pre_enable),
    .tick   (tick)
  );

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    under_run_d = under_run_q;
    expired_d   = 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    reload_d    = reload_q;
`endif

    if (load_fire) begin
      count_d     = load_value;
      under_run_d = 1'b0;
      state_d     = ARMED;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      reload_d    = load_value;
`endif
    end else begin
      unique case (state_q)
        ARMED: begin
          if (start) begin
            if (count_q != '0) begin
              state_d = RUN;
            end else begin
              // Starting an empty count is an immediate expiry.
              state_d     = DONE;
              expired_d   = 1'b1;
              under_run_d = 1'b1;
            end
          end
        end
        RUN: begin
          if (stop) begin
            state_d = ARMED;
          end else if (tick) begin
            if (count_q > ONE) begin
              count_d = count_q - ONE;
            end else begin
              expired_d   = 1'b1;
              under_run_d = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
              if (reload_q != '0) begin
                count_d = reload_q;
              end else begin
                count_d = '0;
                state_d = DONE;
              end
`else
              count_d = '0;
              state_d = DONE;
`endif
            end
          end
        end
        IDLE, DONE: begin
          state_d = state_q;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      under_run_q <= 1'b0;
      expired_q   <= 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      reload_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      under_run_q <= under_run_d;
      expired_q   <= expired_d;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      reload_q    <= reload_d;
`endif
    end
  end

  assign counter    = count_q;
  assign busy       = (state_q == RUN);
  assign load_ready = (state_q != RUN);
  assign expired    = expired_q;
  assign under_run  = under_run_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: vector table plus hand-written corner sequences.
module tb_countdown_timer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       lv = 1'b0, st = 1'b0, sp = 1'b0;
  logic [7:0] val = '0;
  logic       rdy, busy, expd, ur;
  logic [7:0] cnt;

  logic       lv3 = 1'b0, st3 = 1'b0, sp3 = 1'b0;
  logic [7:0] val3 = '0;
  logic       rdy3, busy3, expd3, ur3;
  logic [7:0] cnt3;

  countdown_timer #(.COUNTER_MSB(7), .PRESCALE(0)) dut0 (
    .clk(clk), .rst(rst), .load_valid(lv), .load_ready(rdy), .load_value(val),
    .start(st), .stop(sp), .counter(cnt), .busy(busy), .expired(expd), .under_run(ur)
  );

  countdown_timer #(.COUNTER_MSB(7), .PRESCALE(3)) dut3 (
    .clk(clk), .rst(rst), .load_valid(lv3), .load_ready(rdy3), .load_value(val3),
    .start(st3), .stop(sp3), .counter(cnt3), .busy(busy3), .expired(expd3), .under_run(ur3)
  );

  typedef struct {
    bit         sel3;
    int         tag;
    logic [7:0] cnt;
    logic       busy, expd, ur, rdy;
  } exp_t;

  exp_t sb[$];
  int   tag_n   = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic push(input bit s3, input logic [7:0] c, input logic b, input logic e,
                      input logic u, input logic r);
    exp_t x;
    x.sel3 = s3; x.tag = tag_n; x.cnt = c; x.busy = b; x.expd = e; x.ur = u; x.rdy = r;
    tag_n++;
    sb.push_back(x);
  endtask

  task automatic sb_check();
    exp_t       e;
    logic [7:0] a_cnt;
    logic       a_b, a_e, a_u, a_r;
    n_tests++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL sb_empty: actual=no expectation required=one queued");
      return;
    end
    e = sb.pop_front();
    if (e.sel3) {a_cnt, a_b, a_e, a_u, a_r} = {cnt3, busy3, expd3, ur3, rdy3};
    else        {a_cnt, a_b, a_e, a_u, a_r} = {cnt, busy, expd, ur, rdy};
    if ({a_cnt, a_b, a_e, a_u, a_r} !== {e.cnt, e.busy, e.expd, e.ur, e.rdy}) begin
      n_fail++;
      $display("FAIL chk%0d (dut%0d) cnt/busy/exp/ur/rdy actual=%0d/%b/%b/%b/%b required=%0d/%b/%b/%b/%b",
               e.tag, e.sel3 ? 3 : 0, a_cnt, a_b, a_e, a_u, a_r, e.cnt, e.busy, e.expd, e.ur, e.rdy);
    end
  endtask

  task automatic step0(input logic r, input logic l, input logic [7:0] v, input logic s,
                       input logic p, input logic [7:0] c, input logic b, input logic e,
                       input logic u, input logic rd);
    @(negedge clk);
    rst = r; lv = l; val = v; st = s; sp = p;
    push(1'b0, c, b, e, u, rd);
    @(posedge clk);
    #1;
    sb_check();
  endtask

  task automatic step3(input logic l, input logic [7:0] v, input logic s,
                       input logic [7:0] c, input logic b, input logic e,
                       input logic u, input logic rd);
    @(negedge clk);
    lv3 = l; val3 = v; st3 = s; sp3 = 1'b0;
    push(1'b1, c, b, e, u, rd);
    @(posedge clk);
    #1;
    sb_check();
  endtask

`ifndef COUNTDOWN_AUTO_RELOAD_EN
  typedef struct {
    logic       rst, lv;
    logic [7:0] val;
    logic       st, sp;
    logic [7:0] e_cnt;
    logic       e_busy, e_exp, e_ur, e_rdy;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic l, input logic [7:0] v,
                              input logic s, input logic p, input logic [7:0] c,
                              input logic b, input logic e, input logic u, input logic rd);
    vec_t x;
    x.rst = r; x.lv = l; x.val = v; x.st = s; x.sp = p;
    x.e_cnt = c; x.e_busy = b; x.e_exp = e; x.e_ur = u; x.e_rdy = rd;
    return x;
  endfunction

  vec_t vecs[21];
`endif

  initial begin
`ifndef COUNTDOWN_AUTO_RELOAD_EN
    //             rst lv val st sp | cnt busy exp ur rdy
    vecs[0]  = mk(1, 0, 0, 0, 0,  0, 0, 0, 0, 1);
    vecs[1]  = mk(0, 1, 3, 0, 0,  3, 0, 0, 0, 1);
    vecs[2]  = mk(0, 0, 0, 1, 0,  3, 1, 0, 0, 0);
    vecs[3]  = mk(0, 0, 0, 0, 0,  2, 1, 0, 0, 0);
    vecs[4]  = mk(0, 0, 0, 0, 0,  1, 1, 0, 0, 0);
    vecs[5]  = mk(0, 0, 0, 0, 0,  0, 0, 1, 1, 1);
    vecs[6]  = mk(0, 0, 0, 0, 0,  0, 0, 0, 1, 1);
    vecs[7]  = mk(0, 0, 0, 1, 0,  0, 0, 0, 1, 1);
    vecs[8]  = mk(0, 1, 5, 0, 0,  5, 0, 0, 0, 1);
    vecs[9]  = mk(0, 0, 0, 1, 0,  5, 1, 0, 0, 0);
    vecs[10] = mk(0, 0, 0, 0, 0,  4, 1, 0, 0, 0);
    vecs[11] = mk(0, 0, 0, 0, 0,  3, 1, 0, 0, 0);
    vecs[12] = mk(0, 0, 0, 0, 1,  3, 0, 0, 0, 1);
    vecs[13] = mk(0, 0, 0, 0, 0,  3, 0, 0, 0, 1);
    vecs[14] = mk(0, 0, 0, 1, 0,  3, 1, 0, 0, 0);
    vecs[15] = mk(0, 0, 0, 0, 0,  2, 1, 0, 0, 0);
    vecs[16] = mk(0, 0, 0, 0, 0,  1, 1, 0, 0, 0);
    vecs[17] = mk(0, 0, 0, 0, 0,  0, 0, 1, 1, 1);
    vecs[18] = mk(0, 1, 0, 0, 0,  0, 0, 0, 0, 1);
    vecs[19] = mk(0, 0, 0, 1, 0,  0, 0, 1, 1, 1);
    vecs[20] = mk(0, 1, 4, 0, 0,  4, 0, 0, 0, 1);

    for (int i = 0; i < 21; i++) begin
      step0(vecs[i].rst, vecs[i].lv, vecs[i].val, vecs[i].st, vecs[i].sp,
            vecs[i].e_cnt, vecs[i].e_busy, vecs[i].e_exp, vecs[i].e_ur, vecs[i].e_rdy);
    end

    // PRESCALE=3: load 2, start at E0, counter steps every 4th edge, expiry at E0+8.
    step3(1'b1, 8'd2, 1'b0, 8'd2, 1'b0, 1'b0, 1'b0, 1'b1);
    step3(1'b0, 8'd0, 1'b1, 8'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 9; k++) begin
      step3(1'b0, 8'd0, 1'b0,
            (k < 4) ? 8'd2 : (k < 8) ? 8'd1 : 8'd0,
            (k < 8), (k == 8), (k >= 8), (k >= 8));
    end
`else
    // Auto-reload: load 2 gives counter 2,1,2,1,... with a pulse at each reload.
    step0(1, 0, 0, 0, 0,  0, 0, 0, 0, 1);
    step0(0, 1, 2, 0, 0,  2, 0, 0, 0, 1);
    step0(0, 0, 0, 1, 0,  2, 1, 0, 0, 0);
    for (int k = 1; k <= 6; k++) begin
      step0(0, 0, 0, 0, 0, (k % 2 == 1) ? 8'd1 : 8'd2, 1'b1, (k % 2 == 0), (k >= 2), 1'b0);
    end
    step0(0, 0, 0, 0, 1,  2, 0, 0, 1, 1);
`endif

    // Asynchronous reset while running at count 7.
    step0(0, 1, 10, 0, 0, 10, 0, 0, 0, 1);
    step0(0, 0, 0, 1, 0,  10, 1, 0, 0, 0);
    step0(0, 0, 0, 0, 0,   9, 1, 0, 0, 0);
    step0(0, 0, 0, 0, 0,   8, 1, 0, 0, 0);
    step0(0, 0, 0, 0, 0,   7, 1, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    push(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    sb_check();
    step0(1, 0, 0, 0, 0,  0, 0, 0, 0, 1);
    step0(0, 0, 0, 1, 0,  0, 0, 0, 0, 1);
    step0(0, 0, 0, 1, 0,  0, 0, 0, 0, 1);

    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL sb_drain: actual=%0d left required=0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Loadable, prescaled down-counter that complements the free-running saturating up-counter. It is the "time remaining" side of the same counting function. A value is loaded over a valid/ready handshake, counted down to zero once started, and zero is reported with a one-cycle `expired` pulse and a sticky `under_run` flag. It sits beside the up-counter in the timing block, driving timeouts and watchdog-style deadlines.

## Interface
Parameters:
- `COUNTER_MSB`, default 7: MSB of the count register; width is COUNTER_MSB+1.
- `PRESCALE`, default 0: a count tick occurs every PRESCALE+1 cycles in RUN; 0 means a tick every cycle.

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  reset; asynchronous, active-high
- `load_valid`  in  1  load request
- `load_ready`  out  1  load can be accepted
- `load_value`  in  COUNTER_MSB+1  value to load
- `start`  in  1  begin or resume counting (level sampled)
- `stop`  in  1  pause counting (level sampled)
- `counter`  out  COUNTER_MSB+1  current remaining count
- `busy`  out  1  high while in RUN
- `expired`  out  1  one-cycle pulse on reaching zero
- `under_run`  out  1  sticky expiry flag

## Operation
- States: IDLE, ARMED, RUN, DONE. Reset enters IDLE.
- Reset values: `counter`=0, `under_run`=0, `expired`=0, `busy`=0, `load_ready`=1; prescaler=0.
- `load_ready` = 1 in IDLE, ARMED and DONE; 0 in RUN.
- Load handshake (`load_valid` & `load_ready`):
  - count ← load_value; `under_run` ← 0; state → ARMED.
- ARMED:
  - `start`=1 and count≠0 → RUN, prescaler cleared.
  - `start`=1 and count=0 → DONE, with `expired` ← 1 on that same edge.
  - `start` is ignored in IDLE and DONE.
- RUN, tick cycle (prescaler = PRESCALE):
  - count>1: decrement.
  - count=1: count ← 0, state → DONE, `expired` ← 1, `under_run` ← 1.
  - In all other RUN cycles the prescaler increments and wraps to 0 after PRESCALE.
- `stop`=1 in RUN → ARMED. Count is held and the prescaler is cleared; a later `start` resumes from the held count.
- Priority within one cycle in RUN: `stop` beats tick, and a tick on that same edge is discarded.
- DONE: `counter` holds 0 until the next load. `under_run` stays 1 until a load or reset.
- Arithmetic is unsigned and never wraps below 0.
- An asynchronous reset mid-count forces IDLE and all reset values on the next evaluation; there is no partial completion.

## Timing
- Edge E0 samples `start` in ARMED and sets RUN.
- With PRESCALE=P and loaded N≥1, `expired` is high in the cycle following edge E0+N·(P+1).
- `counter` is registered and reflects the decrement in the cycle after each tick edge.
- `expired` is registered, exactly one cycle wide, and coincides with the first cycle in which `counter`=0 (or the reload value, see Configuration).
- A load in the same cycle as an `expired` pulse is legal in DONE; the pulse is unaffected.

## Configuration
- Macro `COUNTDOWN_AUTO_RELOAD_EN`.
- Defined:
  - A reload register captures `load_value` on every load handshake.
  - On the count=1 tick, count ← reload value, the state stays in RUN, and `expired` and `under_run` still set.
  - A reload value of 0 falls back to DONE.
- Undefined: no reload register; expiry always enters DONE.

## Structure
- Package `countdown_pkg`:
  - State enum typedef `countdown_state_t` (IDLE, ARMED, RUN, DONE).
  - Encoding constants.
- Sub-module `countdown_prescaler`:
  - Inputs: clk, rst, `clear`, `enable`.
  - Output: `tick`.
  - Parameter: PRESCALE.

## Test plan
- Reset, then load 3 with PRESCALE=0, then `start` → `counter` 3,2,1,0 on consecutive cycles; `expired` high for exactly one cycle with `counter`=0; `under_run`=1; `busy` falls.
- PRESCALE=3, load 2, start → `expired` 8 cycles after the start edge; `counter` changes only every 4th cycle.
- Load 5, start, assert `stop` after 2 ticks → `counter`=3 held and `busy`=0; `start` again → expiry 3 ticks later; `load_ready`=0 throughout RUN.
- Load 0 then `start` → DONE with `expired` pulse on the next cycle and no decrement; then load 4 → `under_run` cleared, state ARMED.
- Assert `rst` while RUN at count 7 → all outputs immediately at reset values; `start` without a new load is ignored.
- With `COUNTDOWN_AUTO_RELOAD_EN`, load 2, start → `expired` pulses every 2 ticks, `counter` sequence 2,1,2,1,…; `busy` stays 1.
